data_mem_responder: RTL and testbench

Memory-side responder for the MEM-stage request signals driven out of the EX/MEM pipeline register (MemWriteM, MemtoRegM, ALUOutM, WriteDataM).
- Models a word-addressed data memory with a fixed multi-cycle access latency.
- Holds the pipeline with MemStallM while an access is in flight.
- Returns ReadDataM for loads and flags out-of-range or misaligned accesses on MemFaultM.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

---
 rtl/data_mem_responder_pkg.sv | 15 +
 rtl/data_mem_responder_array.sv | 26 ++
 rtl/data_mem_responder.sv | 123 ++++++++++++
 tb/tb_data_mem_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the MEM-stage data memory responder:
// FSM encodings, default geometry and the word size.
package data_mem_responder_pkg;

   typedef enum logic [1:0] {
      MEMR_IDLE = 2'd0,
      MEMR_BUSY = 2'd1,
      MEMR_DONE = 2'd2
   } memr_state_t;

   localparam int unsigned DEF_DEPTH_WORDS = 1024;
   localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;
   localparam int unsigned WORD_BYTES      = 4;

endpackage

// File: rtl/data_mem_responder_array.sv
// Synchronous single-port word RAM with registered read; contents are never reset.
module data_mem_array #(
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned IDX_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             en,
   input  logic             we,
   input  logic [IDX_W-1:0] index,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[index] <= wdata;
         end else begin
            rdata <= mem[index];
         end
      end
   end

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: multi-cycle word access with pipeline stall,
// load data return and fault reporting for out-of-range/misaligned/conflicting requests.
module data_mem_responder
   import data_mem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
   parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWriteM,
   input  logic        MemtoRegM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemStallM,
   output logic        MemFaultM
);

   localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] LAST_OFFSET = 32'(DEPTH_WORDS * WORD_BYTES - WORD_BYTES);
   localparam logic [3:0]  COUNT_INIT  = 4'(LATENCY - 1);

   memr_state_t state, state_next;
   logic [3:0]  count;
   logic        lat_write, lat_read;
   logic [31:0] lat_addr, lat_data;
   logic        load_ok;
   logic        fault_reg;
   logic [31:0] ram_rdata;

   logic        req;
   logic        cur_write, cur_read;
   logic [31:0] cur_addr, cur_data, offset;
   logic        bad, fire;

   assign req = MemWriteM | MemtoRegM;

   // With LATENCY==1 the access happens at the accept edge, so the live inputs are used.
   assign cur_write = (state == MEMR_IDLE) ? MemWriteM  : lat_write;
   assign cur_read  = (state == MEMR_IDLE) ? MemtoRegM  : lat_read;
   assign cur_addr  = (state == MEMR_IDLE) ? ALUOutM    : lat_addr;
   assign cur_data  = (state == MEMR_IDLE) ? WriteDataM : lat_data;

   // Addresses below the base wrap to huge offsets, so one unsigned compare covers both ends.
   assign offset = cur_addr - BASE_ADDR;
   assign bad    = (offset > LAST_OFFSET) | (cur_addr[1:0] != 2'b00) | (cur_write & cur_read);

   assign fire = ((state == MEMR_IDLE) && req && (LATENCY == 1)) ||
                 ((state == MEMR_BUSY) && (count <= 4'd1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= MEMR_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         MEMR_IDLE: if (req) state_next = (LATENCY == 1) ? MEMR_DONE : MEMR_BUSY;
         MEMR_BUSY: if (count <= 4'd1) state_next = MEMR_DONE;
         MEMR_DONE: state_next = MEMR_IDLE;
         default:   state_next = MEMR_IDLE;
      endcase
   end

   always_comb begin
      MemStallM = 1'b0;
      case (state)
         MEMR_IDLE: MemStallM = req;
         MEMR_BUSY: MemStallM = 1'b1;
         default:   MemStallM = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count     <= 4'd0;
         lat_write <= 1'b0;
         lat_read  <= 1'b0;
         lat_addr  <= 32'd0;
         lat_data  <= 32'd0;
         load_ok   <= 1'b0;
         fault_reg <= 1'b0;
      end else begin
         fault_reg <= 1'b0;
         if ((state == MEMR_IDLE) && req) begin
            lat_write <= MemWriteM;
            lat_read  <= MemtoRegM;
            lat_addr  <= ALUOutM;
            lat_data  <= WriteDataM;
            count     <= COUNT_INIT;
         end else if ((state == MEMR_BUSY) && (count != 4'd0)) begin
            count <= count - 4'd1;
         end
         if (fire) begin
            fault_reg <= bad;
            load_ok   <= cur_read & ~bad;
         end
      end
   end

   data_mem_array #(
      .DEPTH (DEPTH_WORDS),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .en    (fire & ~bad),
      .we    (cur_write),
      .index (offset[IDX_W+1:2]),
      .wdata (cur_data),
      .rdata (ram_rdata)
   );

   // The RAM output register only moves on reads, so gating it gives hold-until-next-DONE.
   assign ReadDataM = load_ok ? ram_rdata : 32'd0;
   assign MemFaultM = fault_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a LATENCY=2 instance and a LATENCY=1 instance.
module tb_data_mem_responder;

   typedef struct packed {
      logic [31:0] rd;
      logic        fault;
      logic [7:0]  tag;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_we, a_re, b_we, b_re;
   logic [31:0] a_addr, a_data, b_addr, b_data;
   logic [31:0] a_rd, b_rd;
   logic        a_stall, a_fault, b_stall, b_fault;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   tests = 0;
   int   fails = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   data_mem_responder #(.LATENCY(2)) dut_a (
      .clk(clk), .reset(reset), .MemWriteM(a_we), .MemtoRegM(a_re),
      .ALUOutM(a_addr), .WriteDataM(a_data),
      .ReadDataM(a_rd), .MemStallM(a_stall), .MemFaultM(a_fault)
   );

   data_mem_responder #(.LATENCY(1)) dut_b (
      .clk(clk), .reset(reset), .MemWriteM(b_we), .MemtoRegM(b_re),
      .ALUOutM(b_addr), .WriteDataM(b_data),
      .ReadDataM(b_rd), .MemStallM(b_stall), .MemFaultM(b_fault)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Monitors: a DONE cycle is a non-stalled cycle that directly follows a stalled one.
   always begin
      @(negedge clk);
      #2;
      if (reset) begin
         prev_a = 1'b0;
      end else begin
         if (prev_a && !a_stall) begin
            if (qa.size() == 0) begin
               tests++; fails++;
               $display("[TB] FAIL a_unexpected_done: got rd=%h fault=%b, required no response", a_rd, a_fault);
            end else begin
               ea = qa.pop_front();
               $display("[TB] A txn %0d: rd=%h fault=%b (exp rd=%h fault=%b)", ea.tag, a_rd, a_fault, ea.rd, ea.fault);
               check($sformatf("a_rd_%0d", ea.tag), a_rd, ea.rd);
               check($sformatf("a_fault_%0d", ea.tag), 32'(a_fault), 32'(ea.fault));
            end
         end
         prev_a = a_stall;
      end
   end

   always begin
      @(negedge clk);
      #2;
      if (reset) begin
         prev_b = 1'b0;
      end else begin
         if (prev_b && !b_stall) begin
            if (qb.size() == 0) begin
               tests++; fails++;
               $display("[TB] FAIL b_unexpected_done: got rd=%h fault=%b, required no response", b_rd, b_fault);
            end else begin
               eb = qb.pop_front();
               $display("[TB] B txn %0d: rd=%h fault=%b (exp rd=%h fault=%b)", eb.tag, b_rd, b_fault, eb.rd, eb.fault);
               check($sformatf("b_rd_%0d", eb.tag), b_rd, eb.rd);
               check($sformatf("b_fault_%0d", eb.tag), 32'(b_fault), 32'(eb.fault));
            end
         end
         prev_b = b_stall;
      end
   end

   // One LATENCY=2 access; optionally swaps address/data after the accept edge.
   task automatic acc_a(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic exp_fault, input logic [7:0] tag,
                        input logic chg, input logic [31:0] alt_addr, input logic [31:0] alt_data);
      int   stalls;
      logic done;
      qa.push_back('{rd: exp_rd, fault: exp_fault, tag: tag});
      a_we = we; a_re = re; a_addr = addr; a_data = data;
      #1;
      stalls = a_stall ? 1 : 0;
      @(posedge clk);
      #1;
      if (chg) begin
         a_addr = alt_addr; a_data = alt_data;
      end else begin
         a_we = 1'b0; a_re = 1'b0;
      end
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (a_stall) stalls++;
         else done = 1'b1;
      end
      if (!done) begin
         tests++; fails++;
         $display("[TB] FAIL a_timeout_%0d: stall still high, required DONE", tag);
      end
      check($sformatf("a_stall_cycles_%0d", tag), 32'(stalls), 32'd2);
      a_we = 1'b0; a_re = 1'b0; a_addr = 32'd0; a_data = 32'd0;
      @(negedge clk);
      #3;
      check($sformatf("a_fault_after_done_%0d", tag), 32'(a_fault), 32'd0);
   endtask

   // One LATENCY=1 access: stall must read 1,0,0 over accept, DONE, idle.
   task automatic acc_b(input logic we, input logic re, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input logic [7:0] tag);
      logic [2:0] pat;
      @(negedge clk);
      qb.push_back('{rd: exp_rd, fault: 1'b0, tag: tag});
      b_we = we; b_re = re; b_addr = addr; b_data = data;
      #1 pat[2] = b_stall;
      @(negedge clk);
      b_we = 1'b0; b_re = 1'b0;
      #1 pat[1] = b_stall;
      @(negedge clk);
      #1 pat[0] = b_stall;
      check($sformatf("b_stall_pattern_%0d", tag), 32'(pat), 32'b100);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] pat;
      reset = 1'b1;
      a_we = 0; a_re = 0; a_addr = 0; a_data = 0;
      b_we = 0; b_re = 0; b_addr = 0; b_data = 0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_a_stall", 32'(a_stall), 32'd0);
      check("reset_a_rd", a_rd, 32'd0);
      check("reset_a_fault", 32'(a_fault), 32'd0);
      check("reset_b_rd", b_rd, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      acc_a(1, 0, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1, 0, 0, 0);
      acc_a(0, 1, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 0, 0);
      acc_a(1, 0, 32'h1000_0010, 32'h1111_1111, 32'h0, 0, 3, 0, 0, 0);
      acc_a(0, 1, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 0, 4, 0, 0, 0);

      // Store aborted by reset while BUSY: no response expected, old value must survive.
      a_we = 1'b1; a_addr = 32'h1000_0010; a_data = 32'h2222_2222;
      @(posedge clk);
      #1 a_we = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_stall", 32'(a_stall), 32'd0);
      check("midreset_rd", a_rd, 32'd0);
      check("midreset_fault", 32'(a_fault), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      a_addr = 32'd0; a_data = 32'd0;
      @(negedge clk);
      #3;
      acc_a(0, 1, 32'h1000_0010, 32'h0, 32'h1111_1111, 0, 5, 0, 0, 0);

      acc_a(1, 0, 32'h1000_0FFC, 32'hCAFE_F00D, 32'h0, 0, 6, 0, 0, 0);
      acc_a(0, 1, 32'h1000_0FFC, 32'h0, 32'hCAFE_F00D, 0, 7, 0, 0, 0);
      acc_a(0, 1, 32'h1000_1000, 32'h0, 32'h0, 1, 8, 0, 0, 0);
      acc_a(0, 1, 32'h0FFF_FFFC, 32'h0, 32'h0, 1, 9, 0, 0, 0);

      acc_a(1, 0, 32'h1000_0000, 32'hAAAA_5555, 32'h0, 0, 10, 0, 0, 0);
      acc_a(1, 0, 32'h1000_0002, 32'hBBBB_BBBB, 32'h0, 1, 11, 0, 0, 0);
      acc_a(0, 1, 32'h1000_0000, 32'h0, 32'hAAAA_5555, 0, 12, 0, 0, 0);
      acc_a(1, 1, 32'h1000_0000, 32'hCCCC_CCCC, 32'h0, 1, 13, 0, 0, 0);
      acc_a(0, 1, 32'h1000_0000, 32'h0, 32'hAAAA_5555, 0, 14, 0, 0, 0);

      acc_a(1, 0, 32'h1000_0024, 32'h0F0F_0F0F, 32'h0, 0, 15, 0, 0, 0);
      acc_a(1, 0, 32'h1000_0020, 32'h1357_2468, 32'h0, 0, 16, 1, 32'h1000_0024, 32'h9999_9999);
      acc_a(0, 1, 32'h1000_0020, 32'h0, 32'h1357_2468, 0, 17, 0, 0, 0);
      acc_a(0, 1, 32'h1000_0024, 32'h0, 32'h0F0F_0F0F, 0, 18, 0, 0, 0);

      acc_b(1, 0, 32'h1000_0008, 32'h1234_5678, 32'h0, 1);
      acc_b(1, 0, 32'h1000_000C, 32'h0BAD_CAFE, 32'h0, 2);
      acc_b(0, 1, 32'h1000_0008, 32'h0, 32'h1234_5678, 3);

      // Back-to-back loads on the LATENCY=1 build.
      @(negedge clk);
      qb.push_back('{rd: 32'h1234_5678, fault: 1'b0, tag: 8'd4});
      qb.push_back('{rd: 32'h0BAD_CAFE, fault: 1'b0, tag: 8'd5});
      b_re = 1'b1; b_addr = 32'h1000_0008;
      #1 pat[3] = b_stall;
      @(negedge clk);
      b_addr = 32'h1000_000C;
      #1 pat[2] = b_stall;
      @(negedge clk);
      #1 pat[1] = b_stall;
      @(negedge clk);
      b_re = 1'b0; b_addr = 32'd0;
      #1 pat[0] = b_stall;
      check("b_back_to_back_pattern", 32'(pat), 32'b1010);
      @(negedge clk);
      #1;
      check("b_idle_after_pair", 32'(b_stall), 32'd0);

      repeat (4) @(negedge clk);
      #3;
      check("a_queue_drained", 32'(qa.size()), 32'd0);
      check("b_queue_drained", 32'(qb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
